// File: rtl/fp_instr_sequencer_if.sv
// FPU request/response bundle between the instruction sequencer and the FPU.
// master: sequencer side (drives instr/valid/flush/out_ready); slave: FPU side.
interface fp_instr_sequencer_if #(
   parameter int INSTR_W = 32,
   parameter int DATA_W  = 32
) ();
   logic [INSTR_W-1:0] instr;
   logic               in_valid;
   logic               in_ready;
   logic               flush;
   logic [DATA_W-1:0]  result;
   logic [4:0]         status;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output instr,
      output in_valid,
      output flush,
      output out_ready,
      input  in_ready,
      input  result,
      input  status,
      input  out_valid
   );

   modport slave (
      input  instr,
      input  in_valid,
      input  flush,
      input  out_ready,
      output in_ready,
      output result,
      output status,
      output out_valid
   );
endinterface

// File: rtl/fp_instr_sequencer.sv
// Instruction sequencer feeding an FPU from a preloaded program memory.
// Ports: clk/rst, program load port, run control (start/length/loop/abort),
// FPU handshake bundle (fpu), run status (busy/done/counters/result/flags).
module fp_instr_sequencer #(
   parameter int INSTR_W         = 32,
   parameter int DATA_W          = 32,
   parameter int DEPTH           = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 16,
   localparam int AW             = $clog2(DEPTH),
   localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               load_we_i,
   input  logic [AW-1:0]      load_addr_i,
   input  logic [INSTR_W-1:0] load_data_i,
   input  logic               start_i,
   input  logic [AW:0]        num_instr_i,
   input  logic               loop_i,
   input  logic               abort_i,
   fp_instr_sequencer_if.master fpu,
   output logic               busy_o,
   output logic               done_o,
   output logic [CNT_W-1:0]   issued_cnt_o,
   output logic [CNT_W-1:0]   retired_cnt_o,
   output logic [DATA_W-1:0]  last_result_o,
   output logic [4:0]         status_acc_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [AW-1:0]      pc_q, pc_d;
   logic [AW:0]        len_q, len_d;
   logic               loop_q, loop_d;
   logic [OW-1:0]      out_q, out_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               in_valid_q, in_valid_d;
   logic               flush_q, flush_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   issued_q, issued_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic [DATA_W-1:0]  last_q, last_d;
   logic [4:0]         stat_q, stat_d;
   logic               out_ready_q;

   logic [INSTR_W-1:0] mem [DEPTH];

   logic active;
   logic accept;
   logic retire;
   logic dec;
   logic is_last;
   logic holding;

   always_ff @(posedge clk_i) begin
      if (load_we_i && state_q == S_IDLE) begin
         mem[load_addr_i] <= load_data_i;
      end
   end

   always_comb begin
      active  = (state_q == S_ISSUE) ||
                (state_q == S_DRAIN);
      accept  = in_valid_q && fpu.in_ready;
      retire  = active && fpu.out_valid &&
                out_ready_q;
      // never let a stray result underflow the count
      dec     = retire && (out_q != '0 || accept);
      is_last = ({1'b0, pc_q} == len_q - 1'b1);
      holding = in_valid_q && !accept;

      state_d    = state_q;
      pc_d       = pc_q;
      len_d      = len_q;
      loop_d     = loop_q;
      out_d      = out_q + OW'(accept) - OW'(dec);
      issued_d   = issued_q;
      retired_d  = retired_q;
      last_d     = last_q;
      stat_d     = stat_q;
      flush_d    = 1'b0;
      in_valid_d = 1'b0;
      instr_d    = instr_q;

      if (active) begin
         if (accept) begin
            issued_d = issued_q + 1'b1;
            pc_d     = is_last ? '0 : pc_q + 1'b1;
         end
         if (retire) begin
            retired_d = retired_q + 1'b1;
            last_d    = fpu.result;
            stat_d    = stat_q | fpu.status;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            out_d = '0;
            if (start_i) begin
               if (num_instr_i != '0) begin
                  state_d   = S_ISSUE;
                  len_d     = num_instr_i;
                  loop_d    = loop_i;
                  pc_d      = '0;
                  issued_d  = '0;
                  retired_d = '0;
                  stat_d    = '0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_ISSUE: begin
            if (accept && is_last && !loop_q) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_d == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            out_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // abort wins over everything, including a same-cycle accept/retire
      if (active && abort_i) begin
         state_d   = S_IDLE;
         out_d     = '0;
         flush_d   = 1'b1;
         pc_d      = pc_q;
         issued_d  = issued_q;
         retired_d = retired_q;
         last_d    = last_q;
         stat_d    = stat_q;
      end

      if (state_d == S_ISSUE) begin
         in_valid_d = holding ||
                      (out_d < OW'(MAX_OUTSTANDING));
      end
      if (in_valid_d && !holding) begin
         instr_d = mem[pc_d];
      end

      busy_d = (state_d == S_ISSUE) ||
               (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         len_q       <= '0;
         loop_q      <= 1'b0;
         out_q       <= '0;
         instr_q     <= '0;
         in_valid_q  <= 1'b0;
         flush_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         issued_q    <= '0;
         retired_q   <= '0;
         last_q      <= '0;
         stat_q      <= '0;
         out_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         len_q       <= len_d;
         loop_q      <= loop_d;
         out_q       <= out_d;
         instr_q     <= instr_d;
         in_valid_q  <= in_valid_d;
         flush_q     <= flush_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         issued_q    <= issued_d;
         retired_q   <= retired_d;
         last_q      <= last_d;
         stat_q      <= stat_d;
         out_ready_q <= 1'b1;
      end
   end

   assign fpu.instr     = instr_q;
   assign fpu.in_valid  = in_valid_q;
   assign fpu.flush     = flush_q;
   assign fpu.out_ready = out_ready_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign issued_cnt_o  = issued_q;
   assign retired_cnt_o = retired_q;
   assign last_result_o = last_q;
   assign status_acc_o  = stat_q;

endmodule

// File: tb/tb_fp_instr_sequencer.sv
// Randomised bench for fp_instr_sequencer with an in-order FPU model and a
// program-level reference (expected issue order, counts, result, flags).
module tb_fp_instr_sequencer;
   localparam int INSTR_W = 32;
   localparam int DATA_W  = 32;
   localparam int DEPTH   = 32;
   localparam int MAXO    = 2;
   localparam int CNT_W   = 16;
   localparam int AW      = $clog2(DEPTH);

   logic               clk = 1'b0;
   logic               rst_ni = 1'b0;
   logic               load_we_i = 1'b0;
   logic [AW-1:0]      load_addr_i = '0;
   logic [INSTR_W-1:0] load_data_i = '0;
   logic               start_i = 1'b0;
   logic [AW:0]        num_instr_i = '0;
   logic               loop_i = 1'b0;
   logic               abort_i = 1'b0;
   logic               busy_o;
   logic               done_o;
   logic [CNT_W-1:0]   issued_cnt_o;
   logic [CNT_W-1:0]   retired_cnt_o;
   logic [DATA_W-1:0]  last_result_o;
   logic [4:0]         status_acc_o;

   fp_instr_sequencer_if #(
      .INSTR_W(INSTR_W),
      .DATA_W (DATA_W)
   ) fpu ();

   fp_instr_sequencer #(
      .INSTR_W        (INSTR_W),
      .DATA_W         (DATA_W),
      .DEPTH          (DEPTH),
      .MAX_OUTSTANDING(MAXO),
      .CNT_W          (CNT_W)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .load_we_i    (load_we_i),
      .load_addr_i  (load_addr_i),
      .load_data_i  (load_data_i),
      .start_i      (start_i),
      .num_instr_i  (num_instr_i),
      .loop_i       (loop_i),
      .abort_i      (abort_i),
      .fpu          (fpu.master),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .issued_cnt_o (issued_cnt_o),
      .retired_cnt_o(retired_cnt_o),
      .last_result_o(last_result_o),
      .status_acc_o (status_acc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                due;
      logic [DATA_W-1:0] res;
      logic [4:0]        st;
   } pend_t;

   int                 n_chk = 0;
   int                 n_err = 0;
   int                 ncyc = 0;
   logic [INSTR_W-1:0] prog [DEPTH];
   pend_t              pq [$];
   logic [4:0]         stat_tab [$];
   int                 lat = 1;
   int                 hold_until = 0;
   int                 rdy_mode = 0;
   bit                 in_run = 0;
   int                 run_len = 0;
   int                 exp_pc = 0;
   int                 exp_iss = 0;
   int                 exp_ret = 0;
   logic [DATA_W-1:0]  exp_last = '0;
   logic [4:0]         exp_stat = '0;
   int                 n_done = 0;
   int                 first_acc = -1;
   int                 last_acc = -1;

   function automatic logic [DATA_W-1:0] res_of(
      logic [INSTR_W-1:0] i);
      return DATA_W'(i) ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(string tag, logic [63:0] got,
                      logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic cyc();
      bit                 acc, ret, held, abt, rst;
      logic [INSTR_W-1:0] hi;
      pend_t              p;
      logic [4:0]         st;
      int                 due;
      unique case (rdy_mode)
         0: fpu.in_ready = 1'b1;
         1: fpu.in_ready = (ncyc % 2) == 0;
         default: fpu.in_ready = 1'($urandom);
      endcase
      if (pq.size() > 0 && pq[0].due <= ncyc &&
          ncyc >= hold_until) begin
         fpu.out_valid = 1'b1;
         fpu.result    = pq[0].res;
         fpu.status    = pq[0].st;
      end else begin
         fpu.out_valid = 1'b0;
         fpu.result    = $urandom;
         fpu.status    = 5'($urandom);
      end
      acc  = fpu.in_valid && fpu.in_ready;
      ret  = fpu.out_valid && fpu.out_ready;
      abt  = abort_i;
      rst  = !rst_ni;
      held = fpu.in_valid && !fpu.in_ready &&
             !abt && !rst;
      hi   = fpu.instr;
      if (rst) begin
         pq.delete();
         in_run = 0;
      end else if (abt) begin
         pq.delete();
         in_run = 0;
      end else begin
         if (ret) begin
            p = pq.pop_front();
            if (in_run) begin
               exp_ret++;
               exp_last = p.res;
               exp_stat |= p.st;
            end
         end
         if (acc) begin
            chk("order", fpu.instr, prog[exp_pc]);
            if (run_len > 0) exp_pc = (exp_pc + 1) % run_len;
            exp_iss++;
            if (first_acc < 0) first_acc = ncyc;
            last_acc = ncyc;
            st = stat_tab.size() > 0 ?
                 stat_tab.pop_front() : 5'($urandom);
            due = ncyc + lat;
            if (pq.size() > 0 && pq[$].due > due)
               due = pq[$].due;
            pq.push_back('{due, res_of(fpu.instr), st});
            chk("outstanding", 64'(exp_iss - exp_ret <= MAXO),
                64'd1);
         end
      end
      @(posedge clk);
      #1;
      ncyc++;
      if (held) begin
         chk("hold_valid", fpu.in_valid, 1);
         chk("hold_instr", fpu.instr, hi);
      end
      if (!rst) chk("flush", fpu.flush, abt);
      if (done_o) begin
         n_done++;
         in_run = 0;
      end
      start_i   = 1'b0;
      abort_i   = 1'b0;
      load_we_i = 1'b0;
   endtask

   task automatic load(int a, logic [INSTR_W-1:0] d);
      load_we_i   = 1'b1;
      load_addr_i = AW'(a);
      load_data_i = d;
      cyc();
      prog[a] = d;
   endtask

   task automatic start_run(int len, bit lp);
      num_instr_i = (AW+1)'(len);
      loop_i      = lp;
      start_i     = 1'b1;
      in_run      = len > 0;
      run_len     = len;
      exp_pc      = 0;
      exp_iss     = 0;
      exp_ret     = 0;
      exp_stat    = '0;
      n_done      = 0;
      first_acc   = -1;
      cyc();
   endtask

   task automatic end_run(string tag, int len);
      int i = 0;
      while (n_done == 0 && i < 3000) begin
         cyc();
         i++;
      end
      chk({tag, "_done"}, n_done, 1);
      chk({tag, "_iss"}, issued_cnt_o, CNT_W'(len));
      chk({tag, "_ret"}, retired_cnt_o, CNT_W'(len));
      chk({tag, "_last"}, last_result_o, exp_last);
      chk({tag, "_stat"}, status_acc_o, exp_stat);
      cyc();
      chk({tag, "_done1"}, n_done, 1);
      chk({tag, "_busy"}, busy_o, 0);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_instr"}, fpu.instr, 0);
      chk({tag, "_inv"}, fpu.in_valid, 0);
      chk({tag, "_flush"}, fpu.flush, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_iss"}, issued_cnt_o, 0);
      chk({tag, "_ret"}, retired_cnt_o, 0);
      chk({tag, "_last"}, last_result_o, 0);
      chk({tag, "_stat"}, status_acc_o, 0);
      chk({tag, "_ordy"}, fpu.out_ready, 0);
   endtask

   initial begin
      int len;
      int k;
      cyc();
      cyc();
      chk_zero("rst");
      rst_ni = 1'b1;
      cyc();
      chk("ordy_on", fpu.out_ready, 1);
      for (int a = 0; a < DEPTH; a++) load(a, $urandom);

      // three instrs, full-rate FPU
      rdy_mode = 0;
      lat      = 1;
      start_run(3, 0);
      chk("s1_busy", busy_o, 1);
      end_run("s1", 3);
      chk("s1_b2b", last_acc - first_acc, 2);
      chk("s1_res", last_result_o, res_of(prog[2]));

      // results withheld: issue stops at the outstanding limit
      hold_until = ncyc + 12;
      start_run(5, 0);
      for (int i = 0; i < 10; i++) cyc();
      chk("s2_iss_lim", issued_cnt_o, MAXO);
      chk("s2_ret0", retired_cnt_o, 0);
      chk("s2_inv", fpu.in_valid, 0);
      end_run("s2", 5);
      hold_until = 0;

      // toggling ready plus ignored start/load mid-run
      rdy_mode = 1;
      lat      = 2;
      start_run(8, 0);
      cyc();
      cyc();
      start_i     = 1'b1;
      num_instr_i = 5;
      load_we_i   = 1'b1;
      load_addr_i = '0;
      load_data_i = ~prog[0];
      cyc();
      chk("s3_busy", busy_o, 1);
      end_run("s3", 8);

      // loop mode, abort after seven accepts
      rdy_mode = 0;
      lat      = 1;
      start_run(2, 1);
      k = 0;
      while (exp_iss < 7 && k < 200) begin
         cyc();
         k++;
      end
      chk("s4_reach7", exp_iss, 7);
      abort_i = 1'b1;
      cyc();
      chk("s4_iss", issued_cnt_o, 7);
      chk("s4_busy", busy_o, 0);
      chk("s4_inv", fpu.in_valid, 0);
      chk("s4_ret", retired_cnt_o, CNT_W'(exp_ret));
      for (int i = 0; i < 4; i++) cyc();
      chk("s4_nodone", n_done, 0);

      // zero-length program
      start_run(0, 0);
      chk("s5_done", done_o, 1);
      chk("s5_busy", busy_o, 0);
      chk("s5_inv", fpu.in_valid, 0);
      cyc();
      chk("s5_done_off", done_o, 0);
      chk("s5_inv2", fpu.in_valid, 0);

      // reset in DRAIN, then re-run with injected flags
      hold_until = ncyc + 60;
      start_run(2, 0);
      for (int i = 0; i < 6; i++) cyc();
      chk("s6_iss", issued_cnt_o, 2);
      chk("s6_busy", busy_o, 1);
      chk("s6_inv", fpu.in_valid, 0);
      rst_ni = 1'b0;
      cyc();
      chk_zero("s6rst");
      rst_ni = 1'b1;
      hold_until = 0;
      cyc();
      stat_tab.push_back(5'b00001);
      stat_tab.push_back(5'b10000);
      start_run(2, 0);
      end_run("s6", 2);
      chk("s6_flags", status_acc_o, 5'b10001);
      chk("s6_res", last_result_o, res_of(prog[1]));

      // random programs and FPU behaviour
      for (int r = 0; r < 8; r++) begin
         for (int j = 0; j < 4; j++)
            load($urandom_range(0, DEPTH - 1), $urandom);
         rdy_mode = $urandom_range(0, 2);
         lat      = $urandom_range(1, 4);
         len      = $urandom_range(1, DEPTH);
         start_run(len, 0);
         end_run("rnd", len);
      end

      $display("Result: errors=%0d of %0d checks",
               n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
